tmr_fault_monitor: RTL and testbench

- Observation end of a triplicated register: receives the three replica values q_1/q_2/q_3 and produces the bitwise-majority value.
- Each sampling cycle, classifies the disagreement as none, a single faulty replica, or an uncorrectable fault.
- Keeps saturating per-replica fault counters and a sticky uncorrectable flag.
- Reports each fault event to a status/logging consumer over a valid/ready handshake with a one-entry holding register.

---
 rtl/tmr_pkg.sv | 21 ++
 rtl/tmr_classifier.sv | 39 +++
 rtl/tmr_fault_monitor.sv | 148 ++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR fault monitor and its classifier.
package tmr_pkg;

    // Width of the triplicated register being observed.
    localparam int TMR_WIDTH = 32;

    // Event code: 0 means all three replicas disagree, otherwise the faulty replica index.
    typedef enum logic [1:0] {
        FC_UNCORR = 2'd0,
        FC_R1     = 2'd1,
        FC_R2     = 2'd2,
        FC_R3     = 2'd3
    } fault_code_t;

    // Event holding register state: empty, or holding an unacknowledged event.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } mon_state_t;

endpackage

// File: rtl/tmr_classifier.sv
// Purely combinational majority voter and disagreement classifier for three replicas.
module tmr_classifier
    import tmr_pkg::*;
#(
    parameter int width = TMR_WIDTH
) (
    input  logic [width-1:0] q1_i,
    input  logic [width-1:0] q2_i,
    input  logic [width-1:0] q3_i,
    output logic [width-1:0] voted_o,
    output logic             faultDetected_o,
    output fault_code_t      faultCode_o
);

    logic eq12;
    logic eq13;
    logic eq23;

    assign voted_o = (q1_i & q2_i) | (q1_i & q3_i) | (q2_i & q3_i);
    assign eq12    = (q1_i == q2_i);
    assign eq13    = (q1_i == q3_i);
    assign eq23    = (q2_i == q3_i);

    // The odd replica out is the one absent from the single agreeing pair; no pair at all is uncorrectable.
    always_comb begin
        faultDetected_o = 1'b1;
        faultCode_o     = FC_UNCORR;
        if (eq12 && eq13) begin
            faultDetected_o = 1'b0;
        end else if (eq12) begin
            faultCode_o = FC_R3;
        end else if (eq13) begin
            faultCode_o = FC_R2;
        end else if (eq23) begin
            faultCode_o = FC_R1;
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Observation end of a triplicated register: votes, classifies faults, counts them
// and reports each fault event through a one-entry valid/ready holding register.
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int width     = TMR_WIDTH,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width-1:0]     q_1,
    input  logic [width-1:0]     q_2,
    input  logic [width-1:0]     q_3,
    input  logic                 sample_en,
    input  logic                 clr_counts,
    output logic [width-1:0]     voted_q,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_code,
    output logic [width-1:0]     evt_value,
    output logic [cnt_width-1:0] err_cnt_1,
    output logic [cnt_width-1:0] err_cnt_2,
    output logic [cnt_width-1:0] err_cnt_3,
    output logic [cnt_width-1:0] drop_cnt,
    output logic                 uncorrectable
);

    localparam logic [cnt_width-1:0] CntMax = '1;
    localparam logic [cnt_width-1:0] CntOne = 1;

    logic        faultDetected;
    fault_code_t faultCode;
    logic        sampledFault;

    mon_state_t       state_q;
    logic             evtValid_q;
    fault_code_t      evtCode_q;
    logic [width-1:0] evtValue_q;

    logic [cnt_width-1:0] errCnt1_q, errCnt1_d;
    logic [cnt_width-1:0] errCnt2_q, errCnt2_d;
    logic [cnt_width-1:0] errCnt3_q, errCnt3_d;
    logic [cnt_width-1:0] dropCnt_q, dropCnt_d;
    logic                 uncorr_q,  uncorr_d;

    tmr_classifier #(
        .width(width)
    ) uClassifier (
        .q1_i            (q_1),
        .q2_i            (q_2),
        .q3_i            (q_3),
        .voted_o         (voted_q),
        .faultDetected_o (faultDetected),
        .faultCode_o     (faultCode)
    );

    assign sampledFault = sample_en && faultDetected;

    // Next counter values: saturating increments per fault class, with a clear request overriding everything.
    always_comb begin
        errCnt1_d = errCnt1_q;
        errCnt2_d = errCnt2_q;
        errCnt3_d = errCnt3_q;
        dropCnt_d = dropCnt_q;
        uncorr_d  = uncorr_q;
        if (sampledFault) begin
            case (faultCode)
                FC_R1:     if (errCnt1_q != CntMax) errCnt1_d = errCnt1_q + CntOne;
                FC_R2:     if (errCnt2_q != CntMax) errCnt2_d = errCnt2_q + CntOne;
                FC_R3:     if (errCnt3_q != CntMax) errCnt3_d = errCnt3_q + CntOne;
                default:   uncorr_d = 1'b1;
            endcase
            if (state_q == HOLD && !evt_ready && dropCnt_q != CntMax) begin
                dropCnt_d = dropCnt_q + CntOne;
            end
        end
        if (clr_counts) begin
            errCnt1_d = '0;
            errCnt2_d = '0;
            errCnt3_d = '0;
            dropCnt_d = '0;
            uncorr_d  = 1'b0;
        end
    end

    // Counter and sticky-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCnt1_q <= '0;
            errCnt2_q <= '0;
            errCnt3_q <= '0;
            dropCnt_q <= '0;
            uncorr_q  <= 1'b0;
        end else begin
            errCnt1_q <= errCnt1_d;
            errCnt2_q <= errCnt2_d;
            errCnt3_q <= errCnt3_d;
            dropCnt_q <= dropCnt_d;
            uncorr_q  <= uncorr_d;
        end
    end

    // Event holding FSM: a handshake with a coincident new fault reloads in place so back-to-back events are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            evtValid_q <= 1'b0;
            evtCode_q  <= FC_UNCORR;
            evtValue_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sampledFault) begin
                        state_q    <= HOLD;
                        evtValid_q <= 1'b1;
                        evtCode_q  <= faultCode;
                        evtValue_q <= voted_q;
                    end
                end
                HOLD: begin
                    if (evt_ready) begin
                        if (sampledFault) begin
                            evtCode_q  <= faultCode;
                            evtValue_q <= voted_q;
                        end else begin
                            state_q    <= IDLE;
                            evtValid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    evtValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid     = evtValid_q;
    assign evt_code      = evtCode_q;
    assign evt_value     = evtValue_q;
    assign err_cnt_1     = errCnt1_q;
    assign err_cnt_2     = errCnt2_q;
    assign err_cnt_3     = errCnt3_q;
    assign drop_cnt      = dropCnt_q;
    assign uncorrectable = uncorr_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Testbench for tmr_fault_monitor: directed vectors, with expected events queued
// by the stimulus and popped by a monitor whenever an event is handed off.
module tb_tmr_fault_monitor;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] value;
    } evtExp_t;

    logic        clk;
    logic        rst;
    logic [31:0] q1, q2, q3;
    logic        sampleEn;
    logic        clrCounts;
    logic [31:0] votedQ;
    logic        evtValid;
    logic        evtReady;
    logic [1:0]  evtCode;
    logic [31:0] evtValue;
    logic [7:0]  errCnt1, errCnt2, errCnt3, dropCnt;
    logic        uncorr;

    evtExp_t expQueue[$];
    int      compared   = 0;
    int      mismatched = 0;

    tmr_fault_monitor #(
        .width(32),
        .cnt_width(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .q_1           (q1),
        .q_2           (q2),
        .q_3           (q3),
        .sample_en     (sampleEn),
        .clr_counts    (clrCounts),
        .voted_q       (votedQ),
        .evt_valid     (evtValid),
        .evt_ready     (evtReady),
        .evt_code      (evtCode),
        .evt_value     (evtValue),
        .err_cnt_1     (errCnt1),
        .err_cnt_2     (errCnt2),
        .err_cnt_3     (errCnt3),
        .drop_cnt      (dropCnt),
        .uncorrectable (uncorr)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the replica values and wait until just after the next rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        q1 = a;
        q2 = b;
        q3 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expectEvent(input logic [1:0] code, input logic [31:0] value);
        evtExp_t e;
        e.code  = code;
        e.value = value;
        expQueue.push_back(e);
    endtask

    // Monitor: every accepted event must match the oldest queued expectation.
    initial begin
        evtExp_t e;
        forever begin
            @(negedge clk);
            if (evtValid === 1'b1 && evtReady === 1'b1) begin
                if (expQueue.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_event: got code %0d value 0x%0h, expected no event", evtCode, evtValue);
                end else begin
                    e = expQueue.pop_front();
                    checkOutput("evt_code", {30'd0, evtCode}, {30'd0, e.code});
                    checkOutput("evt_value", evtValue, e.value);
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b1;
        q1        = 32'h10;
        q2        = 32'h10;
        q3        = 32'h10;
        sampleEn  = 1'b0;
        clrCounts = 1'b0;
        evtReady  = 1'b0;
        #12;
        checkOutput("reset_voted_tracks", votedQ, 32'h10);
        checkOutput("reset_evt_valid", {31'd0, evtValid}, 32'd0);
        checkOutput("reset_evt_code", {30'd0, evtCode}, 32'd0);
        checkOutput("reset_evt_value", evtValue, 32'd0);
        checkOutput("reset_err_cnt_1", {24'd0, errCnt1}, 32'd0);
        checkOutput("reset_drop_cnt", {24'd0, dropCnt}, 32'd0);
        checkOutput("reset_uncorr", {31'd0, uncorr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All replicas agree: no events, no counts.
        sampleEn = 1'b1;
        evtReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h10, 32'h10, 32'h10);
            checkOutput("agree_voted", votedQ, 32'h10);
            checkOutput("agree_evt_valid", {31'd0, evtValid}, 32'd0);
        end
        checkOutput("agree_err_cnt_3", {24'd0, errCnt3}, 32'd0);

        // Single replica-3 fault, accepted immediately.
        expectEvent(2'd3, 32'h10);
        applyStimulus(32'h10, 32'h10, 32'h11);
        checkOutput("r3_evt_valid", {31'd0, evtValid}, 32'd1);
        checkOutput("r3_evt_code", {30'd0, evtCode}, 32'd3);
        checkOutput("r3_err_cnt_3", {24'd0, errCnt3}, 32'd1);
        applyStimulus(32'h10, 32'h10, 32'h10);
        checkOutput("r3_evt_cleared", {31'd0, evtValid}, 32'd0);

        // Replica-2 event held, then a replica-1 fault is dropped.
        evtReady = 1'b0;
        expectEvent(2'd2, 32'h10);
        applyStimulus(32'h10, 32'h11, 32'h10);
        applyStimulus(32'h10, 32'h10, 32'h10);
        applyStimulus(32'h12, 32'h10, 32'h10);
        checkOutput("hold_evt_valid", {31'd0, evtValid}, 32'd1);
        checkOutput("hold_evt_code", {30'd0, evtCode}, 32'd2);
        checkOutput("hold_evt_value", evtValue, 32'h10);
        checkOutput("hold_drop_cnt", {24'd0, dropCnt}, 32'd1);
        checkOutput("hold_err_cnt_1", {24'd0, errCnt1}, 32'd1);
        checkOutput("hold_err_cnt_2", {24'd0, errCnt2}, 32'd1);
        checkOutput("hold_err_cnt_3", {24'd0, errCnt3}, 32'd1);
        evtReady = 1'b1;
        applyStimulus(32'h10, 32'h10, 32'h10);
        checkOutput("hold_released", {31'd0, evtValid}, 32'd0);

        // All three differ: uncorrectable, sticky until cleared.
        q1 = 32'h1;
        q2 = 32'h2;
        q3 = 32'h4;
        #1;
        checkOutput("uncorr_voted", votedQ, 32'h0);
        expectEvent(2'd0, 32'h0);
        applyStimulus(32'h1, 32'h2, 32'h4);
        checkOutput("uncorr_evt_valid", {31'd0, evtValid}, 32'd1);
        checkOutput("uncorr_flag", {31'd0, uncorr}, 32'd1);
        checkOutput("uncorr_err_cnt_1", {24'd0, errCnt1}, 32'd1);
        applyStimulus(32'h10, 32'h10, 32'h10);
        checkOutput("uncorr_sticky", {31'd0, uncorr}, 32'd1);

        // Clear coinciding with a new fault: clear wins on counters, event still generated.
        clrCounts = 1'b1;
        expectEvent(2'd3, 32'h10);
        applyStimulus(32'h10, 32'h10, 32'h11);
        clrCounts = 1'b0;
        checkOutput("clr_uncorr", {31'd0, uncorr}, 32'd0);
        checkOutput("clr_err_cnt_1", {24'd0, errCnt1}, 32'd0);
        checkOutput("clr_err_cnt_3", {24'd0, errCnt3}, 32'd0);
        checkOutput("clr_drop_cnt", {24'd0, dropCnt}, 32'd0);
        checkOutput("clr_evt_valid", {31'd0, evtValid}, 32'd1);
        applyStimulus(32'h10, 32'h10, 32'h10);
        checkOutput("clr_evt_done", {31'd0, evtValid}, 32'd0);

        // Sampling disabled: a disagreement is ignored.
        sampleEn = 1'b0;
        applyStimulus(32'h10, 32'h10, 32'h11);
        applyStimulus(32'h10, 32'h10, 32'h11);
        checkOutput("nosample_evt_valid", {31'd0, evtValid}, 32'd0);
        checkOutput("nosample_err_cnt_3", {24'd0, errCnt3}, 32'd0);
        sampleEn = 1'b1;

        // Back-to-back replica-1 faults: every event delivered, counter saturates.
        for (int i = 0; i < 300; i++) begin
            expectEvent(2'd1, 32'h10);
            applyStimulus(32'h20, 32'h10, 32'h10);
            if (i == 99) checkOutput("sat_err_cnt_1_mid", {24'd0, errCnt1}, 32'd100);
        end
        checkOutput("sat_err_cnt_1", {24'd0, errCnt1}, 32'd255);
        checkOutput("sat_drop_cnt", {24'd0, dropCnt}, 32'd0);
        applyStimulus(32'h10, 32'h10, 32'h10);
        checkOutput("sat_evt_done", {31'd0, evtValid}, 32'd0);
        checkOutput("sat_no_wrap", {24'd0, errCnt1}, 32'd255);

        // Reset during HOLD discards the held event asynchronously.
        evtReady = 1'b0;
        expectEvent(2'd3, 32'h10);
        applyStimulus(32'h10, 32'h10, 32'h11);
        applyStimulus(32'h12, 32'h10, 32'h10);
        checkOutput("prerst_drop_cnt", {24'd0, dropCnt}, 32'd1);
        rst = 1'b1;
        void'(expQueue.pop_back());
        #2;
        checkOutput("midrst_evt_valid", {31'd0, evtValid}, 32'd0);
        checkOutput("midrst_err_cnt_1", {24'd0, errCnt1}, 32'd0);
        checkOutput("midrst_drop_cnt", {24'd0, dropCnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        evtReady = 1'b1;
        expectEvent(2'd2, 32'h30);
        applyStimulus(32'h30, 32'h31, 32'h30);
        checkOutput("postrst_evt_valid", {31'd0, evtValid}, 32'd1);
        checkOutput("postrst_err_cnt_2", {24'd0, errCnt2}, 32'd1);
        applyStimulus(32'h30, 32'h30, 32'h30);
        checkOutput("postrst_evt_done", {31'd0, evtValid}, 32'd0);

        applyStimulus(32'h30, 32'h30, 32'h30);
        checkOutput("queue_drained", expQueue.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
